// File: rtl/dram_ras_cas_seq.sv
// ---------------------------------------------------------------------------
// dram_ras_cas_seq
//
// DRAM timing sequencer for the MSX main-RAM path. It converts the Z80 bus
// strobes into DRAM RAS/CAS/WE and drives the quad 2:1 address multiplexer
// (74157) that sits downstream, so the row address is presented before RAS
// and the column address before CAS. Z80 refresh cycles become RAS-only
// refreshes, or CAS-before-RAS refreshes when the optional macro is defined.
//
// Build option:
//   DRAM_SEQ_CBR_REFRESH_EN  defined   -> CAS-before-RAS refresh
//                            undefined -> RAS-only refresh (default)
//
// Parameters:
//   RAH_CYC  cycles from ras_n falling to mux_s switching to column (1..15)
//   CAS_CYC  cycles from mux_s=1 to cas_n falling                   (1..15)
//   RP_CYC   RAS precharge cycles after any access or refresh       (1..15)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   mreq_n   in   Z80 memory request, active low
//   rd_n     in   Z80 read strobe, active low (qualifier only)
//   wr_n     in   Z80 write strobe, active low
//   rfsh_n   in   Z80 refresh indicator, active low
//   ras_n    out  DRAM row address strobe
//   cas_n    out  DRAM column address strobe
//   we_n     out  DRAM write enable
//   mux_s    out  74157 select: 0 = row (i0), 1 = column (i1)
//   mux_noe  out  74157 output enable, 0 = address driven
//   busy     out  high in every state except IDLE
//
// State table:
//   state | meaning
//   IDLE  | waiting for an armed request
//   ROW   | row address driven onto the DRAM bus, RAS still high
//   RAS   | ras_n low, row hold time running
//   COL   | mux switched to column, waiting to drop CAS
//   CAS   | cas_n low, data phase held while mreq_n stays low
//   RFSH  | refresh cycle (RAS-only or CBR)
//   PRE   | RAS precharge, request input ignored
// ---------------------------------------------------------------------------
module dram_ras_cas_seq #(
  parameter int RAH_CYC = 1,
  parameter int CAS_CYC = 1,
  parameter int RP_CYC  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic mreq_n,
  input  logic rd_n,
  input  logic wr_n,
  input  logic rfsh_n,
  output logic ras_n,
  output logic cas_n,
  output logic we_n,
  output logic mux_s,
  output logic mux_noe,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ROW  = 3'd1,
    RAS  = 3'd2,
    COL  = 3'd3,
    CAS  = 3'd4,
    RFSH = 3'd5,
    PRE  = 3'd6
  } state_t;

  localparam logic [3:0] RAH_LD = 4'(RAH_CYC - 1);
  localparam logic [3:0] CAS_LD = 4'(CAS_CYC - 1);
  localparam logic [3:0] RP_LD  = 4'(RP_CYC - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       armed;
  logic       exit_req;

  // rd_n never changes strobe timing: a CAS cycle with neither rd_n nor
  // wr_n asserted simply has no data phase.
  logic unused_rd_n;
  assign unused_rd_n = rd_n;

  // Releasing mreq_n in any active state aborts or ends the cycle.
  assign exit_req = mreq_n && ((state == ROW) || (state == RAS) ||
                               (state == COL) || (state == CAS) ||
                               (state == RFSH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      armed   <= 1'b0;
      ras_n   <= 1'b1;
      cas_n   <= 1'b1;
      we_n    <= 1'b1;
      mux_s   <= 1'b0;
      mux_noe <= 1'b1;
      busy    <= 1'b0;
    end else begin
      // armed only re-arms on an observed high mreq_n, so a request that
      // is still low after reset is never mistaken for a new one.
      if (mreq_n) begin
        armed <= 1'b1;
      end

      if (exit_req) begin
        state   <= PRE;
        cnt     <= RP_LD;
        ras_n   <= 1'b1;
        cas_n   <= 1'b1;
        we_n    <= 1'b1;
        mux_s   <= 1'b0;
        mux_noe <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (armed && !mreq_n) begin
              armed <= 1'b0;
              busy  <= 1'b1;
              mux_s <= 1'b0;
              if (rfsh_n) begin
                state   <= ROW;
                mux_noe <= 1'b0;
              end else begin
                state <= RFSH;
`ifdef DRAM_SEQ_CBR_REFRESH_EN
                // CBR: the DRAM uses its internal row counter, so the
                // address bus stays undriven.
                cas_n <= 1'b0;
`else
                mux_noe <= 1'b0;
`endif
              end
            end
          end

          ROW: begin
            state <= RAS;
            ras_n <= 1'b0;
            cnt   <= RAH_LD;
          end

          RAS: begin
            if (cnt == 4'd0) begin
              state <= COL;
              mux_s <= 1'b1;
              cnt   <= CAS_LD;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end

          COL: begin
            we_n <= wr_n;
            if (cnt == 4'd0) begin
              state <= CAS;
              cas_n <= 1'b0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end

          CAS: begin
            we_n <= wr_n;
          end

          RFSH: begin
            ras_n <= 1'b0;
          end

          PRE: begin
            if (cnt == 4'd0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end

          default: begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ras_n   <= 1'b1;
            cas_n   <= 1'b1;
            we_n    <= 1'b1;
            mux_s   <= 1'b0;
            mux_noe <= 1'b1;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dram_ras_cas_seq.sv
// ---------------------------------------------------------------------------
// tb_dram_ras_cas_seq
//
// Bench for dram_ras_cas_seq with default parameters. Each record holds the
// inputs sampled on one rising edge and the outputs expected just after it,
// packed as {ras_n, cas_n, we_n, mux_s, mux_noe, busy}.
// ---------------------------------------------------------------------------
module tb_dram_ras_cas_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, mreq_n, rd_n, wr_n, rfsh_n;
  logic ras_n, cas_n, we_n, mux_s, mux_noe, busy;

  dram_ras_cas_seq dut (
    .clk     (clk),
    .rst     (rst),
    .mreq_n  (mreq_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .rfsh_n  (rfsh_n),
    .ras_n   (ras_n),
    .cas_n   (cas_n),
    .we_n    (we_n),
    .mux_s   (mux_s),
    .mux_noe (mux_noe),
    .busy    (busy)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       mreq_n;
    logic       rd_n;
    logic       wr_n;
    logic       rfsh_n;
    logic [5:0] exp;
  } vec_t;

  // {ras_n, cas_n, we_n, mux_s, mux_noe, busy}
  localparam logic [5:0] O_RST  = 6'b111010;
  localparam logic [5:0] O_ROW  = 6'b111001;
  localparam logic [5:0] O_RAS  = 6'b011001;
  localparam logic [5:0] O_COL  = 6'b011101;
  localparam logic [5:0] O_CASR = 6'b001101;
  localparam logic [5:0] O_CASW = 6'b000101;
  localparam logic [5:0] O_PRE  = 6'b111011;
`ifdef DRAM_SEQ_CBR_REFRESH_EN
  localparam logic [5:0] O_RF0  = 6'b101011;
  localparam logic [5:0] O_RF1  = 6'b001011;
`else
  localparam logic [5:0] O_RF0  = 6'b111001;
  localparam logic [5:0] O_RF1  = 6'b011001;
`endif

  vec_t       vecs[$];
  logic [5:0] exp_q[$];
  string      name_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       prev_cas_n = 1'b1;
  logic       prev_mux_s = 1'b0;

  task automatic add(input string nm, input logic r, input logic m,
                     input logic rd, input logic wr, input logic rf,
                     input logic [5:0] e);
    vec_t v;
    v.name = nm; v.rst = r; v.mreq_n = m; v.rd_n = rd; v.wr_n = wr;
    v.rfsh_n = rf; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check_out();
    logic [5:0] got;
    logic [5:0] e;
    string      nm;
    got = {ras_n, cas_n, we_n, mux_s, mux_noe, busy};
    e   = exp_q.pop_front();
    nm  = name_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s: ras/cas/we/s/noe/busy got %b expected %b", nm, got, e);
    end
    if (!prev_cas_n && !cas_n) begin
      n_cmp++;
      if (mux_s !== prev_mux_s) begin
        n_bad++;
        $display("FAIL inv_mux_stable at %s: mux_s got %b expected %b", nm, mux_s, prev_mux_s);
      end
    end
`ifndef DRAM_SEQ_CBR_REFRESH_EN
    if (cas_n === 1'b0) begin
      n_cmp++;
      if (ras_n !== 1'b0) begin
        n_bad++;
        $display("FAIL inv_cas_ras at %s: ras_n got %b expected 0", nm, ras_n);
      end
    end
    if (ras_n === 1'b0) begin
      n_cmp++;
      if (mux_noe !== 1'b0) begin
        n_bad++;
        $display("FAIL inv_ras_noe at %s: mux_noe got %b expected 0", nm, mux_noe);
      end
    end
`endif
    prev_cas_n = cas_n;
    prev_mux_s = mux_s;
  endtask

  // Drive on the falling edge, let the rising edge sample, look 1 ns later.
  task automatic apply(input vec_t v);
    @(negedge clk);
    rst    = v.rst;
    mreq_n = v.mreq_n;
    rd_n   = v.rd_n;
    wr_n   = v.wr_n;
    rfsh_n = v.rfsh_n;
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic step(input string nm, input logic r, input logic m,
                      input logic rd, input logic wr, input logic rf,
                      input logic [5:0] e);
    vec_t v;
    v.name = nm; v.rst = r; v.mreq_n = m; v.rd_n = rd; v.wr_n = wr;
    v.rfsh_n = rf; v.exp = e;
    apply(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;

    //   name        rst mreq rd wr rfsh expected
    add("rst0",      1, 1, 1, 1, 1, O_RST);
    add("rst1",      1, 1, 1, 1, 1, O_RST);
    add("rel0",      0, 1, 1, 1, 1, O_RST);
    add("rel1",      0, 1, 1, 1, 1, O_RST);
    // read: accepted at E
    add("rd_acc",    0, 0, 0, 1, 1, O_ROW);
    add("rd_ras",    0, 0, 0, 1, 1, O_RAS);
    add("rd_col",    0, 0, 0, 1, 1, O_COL);
    add("rd_cas",    0, 0, 0, 1, 1, O_CASR);
    add("rd_hold",   0, 0, 0, 1, 1, O_CASR);
    add("rd_noqual", 0, 0, 1, 1, 1, O_CASR);
    add("rd_exit",   0, 1, 1, 1, 1, O_PRE);
    add("rd_pre",    0, 1, 1, 1, 1, O_PRE);
    add("rd_idle",   0, 1, 1, 1, 1, O_RST);
    // write: wr_n low sampled from E+2
    add("wr_acc",    0, 0, 1, 1, 1, O_ROW);
    add("wr_ras",    0, 0, 1, 1, 1, O_RAS);
    add("wr_col",    0, 0, 1, 0, 1, O_COL);
    add("wr_cas",    0, 0, 1, 0, 1, O_CASW);
    add("wr_hold",   0, 0, 1, 0, 1, O_CASW);
    add("wr_exit",   0, 1, 1, 1, 1, O_PRE);
    add("wr_pre",    0, 1, 1, 1, 1, O_PRE);
    add("wr_idle",   0, 1, 1, 1, 1, O_RST);
    // refresh, three cycles low
    add("rf_acc",    0, 0, 1, 1, 0, O_RF0);
    add("rf_ras",    0, 0, 1, 1, 0, O_RF1);
    add("rf_hold",   0, 0, 1, 1, 0, O_RF1);
    add("rf_exit",   0, 1, 1, 1, 1, O_PRE);
    add("rf_pre",    0, 1, 1, 1, 1, O_PRE);
    add("rf_idle",   0, 1, 1, 1, 1, O_RST);
    // abort right after acceptance: ras_n/cas_n never fall
    add("ab_acc",    0, 0, 0, 1, 1, O_ROW);
    add("ab_exit",   0, 1, 1, 1, 1, O_PRE);
    add("ab_pre",    0, 1, 1, 1, 1, O_PRE);
    add("ab_idle",   0, 1, 1, 1, 1, O_RST);
    // back-to-back: immediate accept from IDLE
    add("bb_acc",    0, 0, 0, 1, 1, O_ROW);
    add("bb_ras",    0, 0, 0, 1, 1, O_RAS);
    add("bb_exit",   0, 1, 1, 1, 1, O_PRE);
    add("bb_pre",    0, 1, 1, 1, 1, O_PRE);
    add("bb_idle",   0, 1, 1, 1, 1, O_RST);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // reset in the middle of CAS, with mreq_n held low afterwards
    step("rs_acc",  0, 0, 0, 1, 1, O_ROW);
    step("rs_ras",  0, 0, 0, 1, 1, O_RAS);
    step("rs_col",  0, 0, 0, 1, 1, O_COL);
    step("rs_cas",  0, 0, 0, 1, 1, O_CASR);
    step("rs_rst",  1, 0, 0, 1, 1, O_RST);
    for (int i = 0; i < 3; i++) begin
      step("rs_ignore", 0, 0, 0, 1, 1, O_RST);
    end
    step("rs_arm",  0, 1, 1, 1, 1, O_RST);
    step("rs_acc2", 0, 0, 0, 1, 1, O_ROW);
    step("rs_ras2", 0, 0, 0, 1, 1, O_RAS);
    step("rs_exit", 0, 1, 1, 1, 1, O_PRE);
    step("rs_pre",  0, 1, 1, 1, 1, O_PRE);
    step("rs_idle", 0, 1, 1, 1, 1, O_RST);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: pending got %0d expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dram_ras_cas_seq.md
Name: dram_ras_cas_seq

Overview:
- DRAM timing sequencer for the MSX main-RAM path; sits directly upstream of the quad 2:1 address multiplexer (74157 model).
- Turns Z80 bus strobes (mreq_n, rd_n, wr_n, rfsh_n) into ras_n, cas_n and we_n.
- Also drives the mux select (mux_s) and mux output enable (mux_noe) in the correct row/column order.
- Performs RAS-only refresh during Z80 refresh cycles.

Parameters:
- RAH_CYC, 1: cycles from ras_n falling to mux_s switching to column (1..15).
- CAS_CYC, 1: cycles from mux_s=1 to cas_n falling (1..15).
- RP_CYC, 2: RAS precharge cycles after any access or refresh (1..15).

Ports:
- clk, in, 1: system clock; all logic on rising edge.
- rst, in, 1: synchronous, active-high reset.
- mreq_n, in, 1: Z80 memory request, active low; synchronous to clk.
- rd_n, in, 1: Z80 read strobe, active low.
- wr_n, in, 1: Z80 write strobe, active low.
- rfsh_n, in, 1: Z80 refresh indicator, active low.
- ras_n, out, 1: DRAM row address strobe.
- cas_n, out, 1: DRAM column address strobe.
- we_n, out, 1: DRAM write enable.
- mux_s, out, 1: to the 74157 s input; 0 = row (i0), 1 = column (i1).
- mux_noe, out, 1: to the 74157 noe input; 0 = address driven.
- busy, out, 1: high in every state except IDLE.

Behaviour:
- All outputs are registered. Reset state:
  - ras_n=1, cas_n=1, we_n=1, mux_s=0, mux_noe=1, busy=0.
  - state=IDLE, counter=0, armed=0.
- armed flag:
  - Set on any edge where mreq_n is sampled high.
  - Cleared when a request is accepted.
  - Consequence: a request held low through reset, or across PRECHARGE into IDLE, is never re-accepted.
- States: IDLE, ROW, RAS, COL, CAS, RFSH, PRE. A 4-bit down-counter times RAS, COL and PRE.
- IDLE:
  - If armed and mreq_n=0 and rfsh_n=1 → ROW (mux_noe=0, mux_s=0).
  - If armed and mreq_n=0 and rfsh_n=0 → RFSH (mux_noe=0, mux_s=0).
  - Otherwise stay in IDLE.
- ROW → RAS after one cycle; ras_n=0, counter=RAH_CYC-1.
- RAS: when counter=0 → COL, mux_s=1, counter=CAS_CYC-1.
- COL: when counter=0 → CAS, cas_n=0.
- CAS:
  - Hold all outputs while mreq_n=0.
  - we_n follows the registered wr_n, one-cycle latency; forced to 1 in every state other than COL and CAS.
  - rd_n only qualifies: if rd_n=1 and wr_n=1 in CAS, cas_n stays low and no data phase is implied.
- RFSH:
  - First cycle: ras_n=0. cas_n=1 and we_n=1 throughout.
  - Hold while mreq_n=0.
- Exit to PRE:
  - From any of ROW, RAS, COL, CAS or RFSH, mreq_n sampled high → PRE on the next edge. This covers aborted cycles.
  - On entry to PRE: ras_n=1, cas_n=1, we_n=1, mux_noe=1, mux_s=0, counter=RP_CYC-1.
- PRE: when counter=0 → IDLE (busy=0). mreq_n is ignored while in PRE.
- Latency with default parameters, counted from the accepting edge E:
  - ras_n falls at E+1.
  - mux_s rises at E+2.
  - cas_n falls at E+3.
  - ras_n and cas_n rise one edge after mreq_n is sampled high.
  - busy falls RP_CYC edges after that.
- Ordering invariants, checked by the bench:
  - mux_s never changes while cas_n=0.
  - cas_n=0 implies ras_n=0 (non-CBR build).
  - mux_noe=0 whenever ras_n=0.
- rst asserted mid-access forces the reset values on the next edge, including ras_n=1 and cas_n=1 immediately; no precharge is enforced.

Optional Feature:
- Macro: DRAM_SEQ_CBR_REFRESH_EN.
- Defined: refresh uses CAS-before-RAS.
  - RFSH entry edge: cas_n=0, mux_noe stays 1.
  - Next edge: ras_n=0.
  - On exit: both strobes rise together, then PRE.
  - The "cas_n=0 implies ras_n=0" invariant is waived for refresh.
- Undefined: RAS-only refresh as described in Behaviour.

Test Plan:
- Reset release with mreq_n=1 → all outputs at reset values; busy=0.
- Read, defaults (mreq_n=0, rd_n=0, rfsh_n=1 held 6 cycles, accepted at edge E) → ras_n=0 @E+1, mux_s=1 @E+2, cas_n=0 @E+3, we_n=1 throughout; mreq_n high → strobes high next edge, busy=0 two edges later.
- Write with wr_n=0 from E+2 → we_n=0 from E+3 while cas_n=0; we_n=1 at exit together with cas_n.
- Refresh (mreq_n=0, rfsh_n=0, 3 cycles) → ras_n=0 @E+1, cas_n=1 and mux_s=0 throughout; with DRAM_SEQ_CBR_REFRESH_EN: cas_n=0 @E, ras_n=0 @E+1, mux_noe=1.
- Abort: mreq_n high at E+1 → PRE by E+2, cas_n never low; mreq_n held low through PRE into IDLE → no new access until mreq_n toggles high then low.
- rst=1 while in CAS → next edge ras_n=1, cas_n=1, mux_noe=1, state IDLE; mreq_n still low after rst drops → ignored.
